// File: rtl/propagation_engine.sv
// propagation_engine
// Latches a K-colour graph snapshot and sweeps neighbour-forbid constraints
// (all nodes read the pre-sweep masks) until a fixpoint, an empty candidate set,
// or the sweep cap. Activity, question-bit and Q-format information-gain terms
// are accumulated with saturation over the whole run.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for start; results and flags of last run held
// S_PROP    | one sweep per cycle, busy high
// S_DONE    | done pulse for one cycle, then back to S_IDLE

module propagation_engine #(
    parameter int NODES        = 9,
    parameter int COLOURS      = 3,
    parameter int MU_PRECISION = 16,
    parameter int MAX_ITERS    = NODES
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic [COLOURS*NODES-1:0]           node_masks_in,
    input  logic [NODES*NODES-1:0]             adjacency,
    input  logic [32*NODES-1:0]                node_question_bits,
    output logic                               busy,
    output logic                               done,
    output logic [COLOURS*NODES-1:0]           result_masks,
    output logic                               converged,
    output logic                               conflict,
    output logic [$clog2(MAX_ITERS+1)-1:0]     iter_count,
    output logic [31:0]                        activity_total,
    output logic [31:0]                        question_bits_total,
    output logic [31:0]                        information_gain_q16
);

    localparam int ITW = $clog2(MAX_ITERS + 1);
    localparam logic [ITW-1:0] ITER_LAST = ITW'(MAX_ITERS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PROP = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // log2 table is stored in Q16; rescale to the configured fraction width
    localparam int SH_L = (MU_PRECISION >= 16) ? (MU_PRECISION - 16) : 0;
    localparam int SH_R = (MU_PRECISION >= 16) ? 0 : (16 - MU_PRECISION);
    localparam logic [63:0] L2 = (64'd65536  << SH_L) >> SH_R;
    localparam logic [63:0] L3 = (64'd103872 << SH_L) >> SH_R;
    localparam logic [63:0] L4 = (64'd131072 << SH_L) >> SH_R;

    logic [1:0]               r_state;
    logic [COLOURS*NODES-1:0] r_masks;
    logic [NODES*NODES-1:0]   r_adj;
    logic [32*NODES-1:0]      r_qbits;
    logic [ITW-1:0]           r_iter;
    logic [31:0]              r_act;
    logic [31:0]              r_q;
    logic [31:0]              r_gain;
    logic                     r_conv;
    logic                     r_conf;

    logic [COLOURS*NODES-1:0] w_cand;
    logic [COLOURS-1:0]       w_forbid;
    logic [COLOURS-1:0]       w_mask_i;
    logic [COLOURS-1:0]       w_cand_i;
    logic [63:0]              w_act_inc;
    logic [63:0]              w_q_inc;
    logic [63:0]              w_gain_inc;
    logic                     w_any_empty;
    logic                     w_changed;

    function automatic logic [63:0] gain_lut(input int pc);
        case (pc)
            2:       return L2;
            3:       return L3;
            4:       return L4;
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [63:0] b);
        logic [64:0] s;
        s = {33'd0, a} + {1'b0, b};
        return (s > 65'h0_FFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    // One Jacobi sweep over the pre-sweep masks plus the per-sweep accumulator increments
    always_comb begin
        w_cand      = '0;
        w_forbid    = '0;
        w_mask_i    = '0;
        w_cand_i    = '0;
        w_act_inc   = '0;
        w_q_inc     = '0;
        w_gain_inc  = '0;
        w_any_empty = 1'b0;
        for (int i = 0; i < NODES; i++) begin
            w_forbid = '0;
            w_mask_i = r_masks[i*COLOURS +: COLOURS];
            for (int j = 0; j < NODES; j++) begin
                if (j != i && r_adj[i*NODES + j] &&
                    $countones(r_masks[j*COLOURS +: COLOURS]) == 1)
                    w_forbid = w_forbid | r_masks[j*COLOURS +: COLOURS];
            end
            w_cand_i = w_mask_i & ~w_forbid;
            w_cand[i*COLOURS +: COLOURS] = w_cand_i;
            if (w_cand_i == '0)
                w_any_empty = 1'b1;
            if ($countones(w_cand_i) == 1 && $countones(w_mask_i) != 1) begin
                w_act_inc  = w_act_inc + 64'($countones(w_mask_i & ~w_cand_i)) + 64'd1;
                w_q_inc    = w_q_inc + {32'd0, r_qbits[i*32 +: 32]};
                w_gain_inc = w_gain_inc + gain_lut($countones(w_mask_i));
            end
        end
        w_changed = (w_cand != r_masks);
    end

    // Control FSM, snapshot latch, sweep commit and termination; reset wins over everything
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_masks <= '0;
            r_adj   <= '0;
            r_qbits <= '0;
            r_iter  <= '0;
            r_act   <= '0;
            r_q     <= '0;
            r_gain  <= '0;
            r_conv  <= 1'b0;
            r_conf  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_masks <= node_masks_in;
                        r_adj   <= adjacency;
                        r_qbits <= node_question_bits;
                        r_iter  <= '0;
                        r_act   <= '0;
                        r_q     <= '0;
                        r_gain  <= '0;
                        r_conv  <= 1'b0;
                        r_conf  <= 1'b0;
                        r_state <= S_PROP;
                    end
                end
                S_PROP: begin
                    r_masks <= w_cand;
                    r_iter  <= r_iter + ITW'(1);
                    r_act   <= sat_add(r_act, w_act_inc);
                    r_q     <= sat_add(r_q, w_q_inc);
                    r_gain  <= sat_add(r_gain, w_gain_inc);
                    if (w_any_empty) begin
                        r_conf  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (!w_changed) begin
                        r_conv  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (r_iter == ITER_LAST) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy                 = (r_state == S_PROP);
    assign done                 = (r_state == S_DONE);
    assign result_masks         = r_masks;
    assign converged            = r_conv;
    assign conflict             = r_conf;
    assign iter_count           = r_iter;
    assign activity_total       = r_act;
    assign question_bits_total  = r_q;
    assign information_gain_q16 = r_gain;

endmodule

// File: tb/tb_propagation_engine.sv
// Bench for propagation_engine: directed scenarios plus randomized graphs checked
// against a sweep-level reference model.
module tb_propagation_engine;

    localparam int N = 9;
    localparam int C = 3;
    localparam longint CAP = 64'h0000_0000_FFFF_FFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n, start;
    logic [C*N-1:0]   masks_in;
    logic [N*N-1:0]   adj_in;
    logic [32*N-1:0]  q_in;
    logic             busy, done, conv, conf;
    logic [C*N-1:0]   res;
    logic [3:0]       iter;
    logic [31:0]      act, qt, gain;

    logic             c_start;
    logic [8:0]       c_masks, c_adj, c_res;
    logic [95:0]      c_q;
    logic             c_busy, c_done, c_conv, c_conf;
    logic [0:0]       c_iter;
    logic [31:0]      c_act, c_qt, c_gain;

    propagation_engine #(.NODES(N), .COLOURS(C), .MU_PRECISION(16), .MAX_ITERS(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .node_masks_in(masks_in), .adjacency(adj_in), .node_question_bits(q_in),
        .busy(busy), .done(done), .result_masks(res), .converged(conv), .conflict(conf),
        .iter_count(iter), .activity_total(act), .question_bits_total(qt),
        .information_gain_q16(gain)
    );

    propagation_engine #(.NODES(3), .COLOURS(3), .MU_PRECISION(16), .MAX_ITERS(1)) dut_cap (
        .clk(clk), .rst_n(rst_n), .start(c_start),
        .node_masks_in(c_masks), .adjacency(c_adj), .node_question_bits(c_q),
        .busy(c_busy), .done(c_done), .result_masks(c_res), .converged(c_conv), .conflict(c_conf),
        .iter_count(c_iter), .activity_total(c_act), .question_bits_total(c_qt),
        .information_gain_q16(c_gain)
    );

    int errors = 0;
    int checks = 0;

    int        m_mask[N];
    bit        m_adj[N][N];
    bit [31:0] m_q[N];

    int     e_mask[N];
    bit     e_conv, e_conf;
    int     e_iter;
    longint e_act, e_q, e_gain;

    task automatic clear_graph();
        for (int i = 0; i < N; i++) begin
            m_mask[i] = 1;
            m_q[i] = 0;
            for (int j = 0; j < N; j++) m_adj[i][j] = 1'b0;
        end
    endtask

    task automatic link(input int a, input int b);
        m_adj[a][b] = 1'b1;
        m_adj[b][a] = 1'b1;
    endtask

    task automatic load_inputs();
        for (int i = 0; i < N; i++) begin
            masks_in[i*C +: C] = m_mask[i][C-1:0];
            q_in[i*32 +: 32] = m_q[i];
            for (int j = 0; j < N; j++) adj_in[i*N + j] = m_adj[i][j];
        end
    endtask

    function automatic logic [C*N-1:0] pack_expected();
        logic [C*N-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i*C +: C] = e_mask[i][C-1:0];
        return v;
    endfunction

    // Reference: sweeps applied as whole-graph steps with set arithmetic on int masks
    task automatic model(input int maxit);
        int cur[N];
        int nxt[N];
        int forb;
        int lg[5];
        bit any_empty, changed;
        lg = '{0, 0, 65536, 103872, 131072};
        cur = m_mask;
        e_act = 0; e_q = 0; e_gain = 0; e_iter = 0; e_conv = 0; e_conf = 0;
        for (int it = 1; it <= maxit; it++) begin
            any_empty = 0;
            changed = 0;
            for (int i = 0; i < N; i++) begin
                forb = 0;
                for (int j = 0; j < N; j++)
                    if (j != i && m_adj[i][j] && $countones(cur[j]) == 1) forb = forb | cur[j];
                nxt[i] = cur[i] & ~forb & ((1 << C) - 1);
                if ($countones(nxt[i]) == 1 && $countones(cur[i]) > 1) begin
                    e_act += $countones(cur[i]) - $countones(nxt[i]) + 1;
                    e_q += longint'(m_q[i]);
                    e_gain += lg[$countones(cur[i])];
                    if (e_act > CAP) e_act = CAP;
                    if (e_q > CAP) e_q = CAP;
                    if (e_gain > CAP) e_gain = CAP;
                end
                if (nxt[i] != cur[i]) changed = 1;
                if (nxt[i] == 0) any_empty = 1;
            end
            cur = nxt;
            e_iter = it;
            if (any_empty) begin e_conf = 1; break; end
            if (!changed) begin e_conv = 1; break; end
        end
        e_mask = cur;
    endtask

    task automatic run_main(output int sweeps, output bit got_done, output logic done_after);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        sweeps = 0;
        got_done = 0;
        for (int k = 0; k < 200; k++) begin
            if (busy === 1'b1) sweeps++;
            if (done === 1'b1) begin got_done = 1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        done_after = done;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; c_start = 1'b0;
        masks_in = '0; adj_in = '0; q_in = '0; c_masks = '0; c_adj = '0; c_q = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, res, conv, conf, iter, act, qt, gain} !== '0) begin
            errors++;
            $display("FAIL reset_main: got busy=%b done=%b res=%h conv=%b conf=%b iter=%0d act=%0d q=%0d gain=%0d, need all 0",
                     busy, done, res, conv, conf, iter, act, qt, gain);
        end
        checks++;
        if ({c_busy, c_done, c_res, c_conv, c_conf, c_iter, c_act, c_qt, c_gain} !== '0) begin
            errors++;
            $display("FAIL reset_cap: got res=%h iter=%0d busy=%b done=%b, need all 0", c_res, c_iter, c_busy, c_done);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic setup_path();
        clear_graph();
        m_mask[0] = 1; m_mask[1] = 3; m_mask[2] = 7;
        link(0, 1); link(1, 2);
        m_q[0] = 5; m_q[1] = 7; m_q[2] = 9;
        load_inputs();
    endtask

    task automatic test_path();
        int sw; bit gd; logic da;
        setup_path();
        run_main(sw, gd, da);
        checks++; if (!gd) begin errors++; $display("FAIL path_done: no done within bound"); end
        checks++; if (sw != 3) begin errors++; $display("FAIL path_busy_cycles: got %0d need 3", sw); end
        checks++; if (da !== 1'b0) begin errors++; $display("FAIL path_done_pulse: done still %b a cycle later, need 0", da); end
        checks++; if (res[8:0] !== 9'b101_010_001) begin errors++; $display("FAIL path_result: got %b need 101010001", res[8:0]); end
        checks++; if (conv !== 1'b1 || conf !== 1'b0) begin errors++; $display("FAIL path_flags: got conv=%b conf=%b need 1 0", conv, conf); end
        checks++; if (iter !== 4'd3) begin errors++; $display("FAIL path_iter: got %0d need 3", iter); end
        checks++; if (act !== 32'd2) begin errors++; $display("FAIL path_activity: got %0d need 2", act); end
        checks++; if (qt !== 32'd7) begin errors++; $display("FAIL path_question: got %0d need 7", qt); end
        checks++; if (gain !== 32'd65536) begin errors++; $display("FAIL path_gain: got %0d need 65536", gain); end
    endtask

    task automatic test_conflict();
        int sw; bit gd; logic da;
        clear_graph();
        link(0, 1);
        load_inputs();
        run_main(sw, gd, da);
        checks++; if (!gd) begin errors++; $display("FAIL conflict_done: no done within bound"); end
        checks++; if (conf !== 1'b1 || conv !== 1'b0) begin errors++; $display("FAIL conflict_flags: got conf=%b conv=%b need 1 0", conf, conv); end
        checks++; if (iter !== 4'd1) begin errors++; $display("FAIL conflict_iter: got %0d need 1", iter); end
        checks++; if (res[5:0] !== 6'b0) begin errors++; $display("FAIL conflict_result: got %b need 000000", res[5:0]); end
        checks++; if (act !== 32'd0) begin errors++; $display("FAIL conflict_activity: got %0d need 0", act); end
    endtask

    task automatic test_cap();
        int sw; bit gd;
        c_masks = {3'b111, 3'b011, 3'b001};
        c_adj = '0;
        c_adj[1] = 1'b1; c_adj[3] = 1'b1; c_adj[5] = 1'b1; c_adj[7] = 1'b1;
        c_q = {32'd9, 32'd7, 32'd5};
        @(negedge clk); c_start = 1'b1;
        @(negedge clk); c_start = 1'b0;
        sw = 0; gd = 0;
        for (int k = 0; k < 50; k++) begin
            if (c_busy === 1'b1) sw++;
            if (c_done === 1'b1) begin gd = 1; break; end
            @(negedge clk);
        end
        checks++; if (!gd) begin errors++; $display("FAIL cap_done: no done within bound"); end
        checks++; if (sw != 1) begin errors++; $display("FAIL cap_busy_cycles: got %0d need 1", sw); end
        checks++; if (c_res !== 9'b111_010_001) begin errors++; $display("FAIL cap_result: got %b need 111010001", c_res); end
        checks++; if (c_conv !== 1'b0 || c_conf !== 1'b0) begin errors++; $display("FAIL cap_flags: got conv=%b conf=%b need 0 0", c_conv, c_conf); end
        checks++; if (c_iter !== 1'b1) begin errors++; $display("FAIL cap_iter: got %0d need 1", c_iter); end
        checks++; if (c_act !== 32'd2 || c_qt !== 32'd7 || c_gain !== 32'd65536) begin
            errors++; $display("FAIL cap_accum: got act=%0d q=%0d gain=%0d need 2 7 65536", c_act, c_qt, c_gain);
        end
        @(negedge clk);
    endtask

    task automatic test_self_loop();
        int sw; bit gd; logic da;
        clear_graph();
        m_adj[0][0] = 1'b1;
        load_inputs();
        run_main(sw, gd, da);
        checks++; if (!gd) begin errors++; $display("FAIL self_loop_done: no done within bound"); end
        checks++; if (conv !== 1'b1 || conf !== 1'b0 || iter !== 4'd1) begin
            errors++; $display("FAIL self_loop_flags: got conv=%b conf=%b iter=%0d need 1 0 1", conv, conf, iter);
        end
        checks++; if (res !== masks_in) begin errors++; $display("FAIL self_loop_result: got %h need %h", res, masks_in); end
    endtask

    task automatic test_zero_mask();
        int sw; bit gd; logic da;
        clear_graph();
        m_mask[4] = 0;
        load_inputs();
        run_main(sw, gd, da);
        checks++; if (!gd) begin errors++; $display("FAIL zero_mask_done: no done within bound"); end
        checks++; if (conf !== 1'b1 || conv !== 1'b0 || iter !== 4'd1) begin
            errors++; $display("FAIL zero_mask_flags: got conf=%b conv=%b iter=%0d need 1 0 1", conf, conv, iter);
        end
    endtask

    task automatic test_saturation();
        int sw; bit gd; logic da;
        clear_graph();
        for (int k = 1; k < N; k++) begin
            m_mask[k] = 3;
            link(0, k);
        end
        for (int k = 0; k < N; k++) m_q[k] = 32'hFFFF_FFFF;
        load_inputs();
        model(N);
        run_main(sw, gd, da);
        checks++; if (!gd) begin errors++; $display("FAIL sat_done: no done within bound"); end
        checks++; if (qt !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_question: got %h need ffffffff", qt); end
        checks++; if (act !== e_act[31:0] || gain !== e_gain[31:0]) begin
            errors++; $display("FAIL sat_other: got act=%0d gain=%0d need %0d %0d", act, gain, e_act, e_gain);
        end
        checks++; if (iter !== 4'(e_iter) || conv !== e_conv) begin
            errors++; $display("FAIL sat_iter: got iter=%0d conv=%b need %0d %b", iter, conv, e_iter, e_conv);
        end
    endtask

    task automatic test_reset_midrun();
        int sw; bit gd; logic da; bit saw_done;
        setup_path();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, res, conv, conf, iter, act, qt, gain} !== '0) begin
            errors++;
            $display("FAIL midrun_reset: got busy=%b done=%b res=%h iter=%0d act=%0d, need all 0", busy, done, res, iter, act);
        end
        rst_n = 1'b1;
        saw_done = 0;
        repeat (4) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) saw_done = 1;
        end
        checks++; if (saw_done) begin errors++; $display("FAIL midrun_quiet: got done/busy activity after reset, need none"); end
        run_main(sw, gd, da);
        checks++; if (!gd || res[8:0] !== 9'b101_010_001 || iter !== 4'd3 || conv !== 1'b1) begin
            errors++; $display("FAIL midrun_rerun: got done=%b res=%b iter=%0d conv=%b need 1 101010001 3 1", gd, res[8:0], iter, conv);
        end
    endtask

    task automatic test_start_midrun();
        bit gd;
        setup_path();
        @(negedge clk); start = 1'b1;
        @(negedge clk);
        masks_in = {N{3'b111}};
        adj_in = '1;
        q_in = {N{32'd1000}};
        @(negedge clk);
        start = 1'b0;
        gd = 0;
        for (int k = 0; k < 50; k++) begin
            if (done === 1'b1) begin gd = 1; break; end
            @(negedge clk);
        end
        checks++; if (!gd) begin errors++; $display("FAIL start_midrun_done: no done within bound"); end
        checks++; if (res[8:0] !== 9'b101_010_001 || iter !== 4'd3 || qt !== 32'd7 || act !== 32'd2) begin
            errors++; $display("FAIL start_midrun_result: got res=%b iter=%0d q=%0d act=%0d need 101010001 3 7 2", res[8:0], iter, qt, act);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        int sw; bit gd; logic da;
        logic [C*N-1:0] exp_res;
        for (int t = 0; t < 25; t++) begin
            clear_graph();
            for (int i = 0; i < N; i++) begin
                m_mask[i] = ($urandom_range(0, 29) == 0) ? 0 : int'($urandom_range(1, 7));
                m_q[i] = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 1000);
                for (int j = i; j < N; j++) begin
                    if (j == i) m_adj[i][i] = ($urandom_range(0, 5) == 0);
                    else if ($urandom_range(0, 2) == 0) link(i, j);
                end
            end
            load_inputs();
            model(N);
            exp_res = pack_expected();
            run_main(sw, gd, da);
            checks++; if (!gd) begin errors++; $display("FAIL rand%0d_done: no done within bound", t); end
            checks++; if (sw != e_iter) begin errors++; $display("FAIL rand%0d_busy: got %0d need %0d", t, sw, e_iter); end
            checks++; if (res !== exp_res) begin errors++; $display("FAIL rand%0d_result: got %h need %h", t, res, exp_res); end
            checks++; if (conv !== e_conv || conf !== e_conf) begin
                errors++; $display("FAIL rand%0d_flags: got conv=%b conf=%b need %b %b", t, conv, conf, e_conv, e_conf);
            end
            checks++; if (iter !== 4'(e_iter)) begin errors++; $display("FAIL rand%0d_iter: got %0d need %0d", t, iter, e_iter); end
            checks++; if (act !== e_act[31:0]) begin errors++; $display("FAIL rand%0d_activity: got %0d need %0d", t, act, e_act); end
            checks++; if (qt !== e_q[31:0]) begin errors++; $display("FAIL rand%0d_question: got %0d need %0d", t, qt, e_q); end
            checks++; if (gain !== e_gain[31:0]) begin errors++; $display("FAIL rand%0d_gain: got %0d need %0d", t, gain, e_gain); end
        end
    endtask

    initial begin
        test_reset();
        test_path();
        test_conflict();
        test_cap();
        test_self_loop();
        test_zero_mask();
        test_saturation();
        test_reset_midrun();
        test_start_midrun();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
